// File: rtl/generation_controller_pkg.sv
// Shared types and reset values for the Conway grid generation sequencer.
package generation_controller_pkg;

  // Sequencer states: pattern load, single step, free-run wait and free-run update.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STEP_UPD = 3'd2,
    WAIT     = 3'd3,
    RUN_UPD  = 3'd4
  } gen_state_t;

  localparam gen_state_t STATE_RESET    = IDLE;
  localparam logic       GEN_DONE_RESET = 1'b0;

endpackage

// File: rtl/interval_timer.sv
// Down-counter that paces free-run generations; reloads on LOAD, holds at zero.
module interval_timer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    LOAD,
  input  logic [PERIOD_WIDTH-1:0] LOAD_VALUE,
  output logic                    ZERO
);

  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic [PERIOD_WIDTH-1:0] cnt_d;

  // Reload takes precedence; otherwise count down until zero and stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = LOAD_VALUE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/generation_controller.sv
// Sequencer driving WRITE_ENABLE / LOAD_RUN of the grid memory: pattern load,
// single-step and free-running generations with optional generation limit.
//
// Control inputs are levels sampled on every rising edge; there is no
// valid/ready handshake. A request is acted on only in IDLE (STOP only in
// WAIT/RUN_UPD); requests seen in other states are dropped, not queued.
// All outputs come from registers or from the state register alone.
module generation_controller
  import generation_controller_pkg::*;
#(
  parameter int PERIOD_WIDTH = 16,
  parameter int GEN_WIDTH    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    LOAD_REQ,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    STEP,
  input  logic [PERIOD_WIDTH-1:0] PERIOD,
  input  logic [GEN_WIDTH-1:0]    GEN_LIMIT,
  output logic                    WRITE_ENABLE,
  output logic                    LOAD_RUN,
  output logic                    RUNNING,
  output logic [GEN_WIDTH-1:0]    GEN_COUNT,
  output logic                    GEN_DONE,
  output gen_state_t              DBG_STATE
);

  gen_state_t           state_q;
  gen_state_t           state_d;
  logic [GEN_WIDTH-1:0] gen_count_q;
  logic [GEN_WIDTH-1:0] gen_count_d;
  logic [GEN_WIDTH-1:0] gen_count_inc;
  logic                 gen_done_q;
  logic                 gen_done_d;
  logic                 timer_load;
  logic                 timer_zero;

  interval_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_interval_timer (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .LOAD      (timer_load),
    .LOAD_VALUE(PERIOD),
    .ZERO      (timer_zero)
  );

  assign gen_count_inc = gen_count_q + 1'b1;

  // Next-state logic; the timer is reloaded on every entry to WAIT.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD_REQ) begin
          state_d = LOAD;
        end else if (STEP) begin
          state_d = STEP_UPD;
        end else if (START) begin
          state_d    = WAIT;
          timer_load = 1'b1;
        end
      end
      LOAD:     state_d = IDLE;
      STEP_UPD: state_d = IDLE;
      WAIT: begin
        if (STOP) begin
          state_d = IDLE;
        end else if (timer_zero) begin
          state_d = RUN_UPD;
        end
      end
      RUN_UPD: begin
        // The write in this cycle always completes; only the follow-on is chosen.
        if (STOP || ((GEN_LIMIT != '0) && (gen_count_inc == GEN_LIMIT))) begin
          state_d = IDLE;
        end else begin
          state_d    = WAIT;
          timer_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Generation counter: cleared by a pattern load, bumped by every grid-logic write.
  always_comb begin
    gen_count_d = gen_count_q;
    gen_done_d  = 1'b0;
    case (state_q)
      LOAD: gen_count_d = '0;
      STEP_UPD, RUN_UPD: begin
        gen_count_d = gen_count_inc;
        gen_done_d  = 1'b1;
      end
      default: gen_count_d = gen_count_q;
    endcase
  end

  // State, counter and completion-pulse registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= STATE_RESET;
      gen_count_q <= '0;
      gen_done_q  <= GEN_DONE_RESET;
    end else begin
      state_q     <= state_d;
      gen_count_q <= gen_count_d;
      gen_done_q  <= gen_done_d;
    end
  end

  assign WRITE_ENABLE = (state_q == LOAD) || (state_q == STEP_UPD) || (state_q == RUN_UPD);
  assign LOAD_RUN     = (state_q == STEP_UPD) || (state_q == WAIT) || (state_q == RUN_UPD);
  assign RUNNING      = (state_q == WAIT) || (state_q == RUN_UPD);
  assign GEN_COUNT    = gen_count_q;
  assign GEN_DONE     = gen_done_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_generation_controller.sv
// Directed bench for generation_controller with write/done scoreboards.
module tb_generation_controller;
  import generation_controller_pkg::*;

  localparam int PW = 16;
  localparam int GW = 16;
  localparam int WW = 32 + 1 + GW;  // {cycle, load_run, gen_count}
  localparam int DW = 32 + GW;      // {cycle, gen_count}

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          LOAD_REQ = 1'b0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic          STEP = 1'b0;
  logic [PW-1:0] PERIOD = '0;
  logic [GW-1:0] GEN_LIMIT = '0;
  logic          WRITE_ENABLE;
  logic          LOAD_RUN;
  logic          RUNNING;
  logic [GW-1:0] GEN_COUNT;
  logic          GEN_DONE;
  gen_state_t    DBG_STATE;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [GW-1:0] exp_cnt = '0;
  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] done_q[$];

  generation_controller #(
    .PERIOD_WIDTH(PW),
    .GEN_WIDTH   (GW)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .LOAD_REQ    (LOAD_REQ),
    .START       (START),
    .STOP        (STOP),
    .STEP        (STEP),
    .PERIOD      (PERIOD),
    .GEN_LIMIT   (GEN_LIMIT),
    .WRITE_ENABLE(WRITE_ENABLE),
    .LOAD_RUN    (LOAD_RUN),
    .RUNNING     (RUNNING),
    .GEN_COUNT   (GEN_COUNT),
    .GEN_DONE    (GEN_DONE),
    .DBG_STATE   (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- helpers / driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one expected memory write (and, for grid-logic writes, its GEN_DONE pulse).
  task automatic expect_write(input int at, input logic lr, input logic [GW-1:0] cnt);
    exp_q.push_back({32'(at), lr, cnt});
    if (lr) done_q.push_back({32'(at + 1), cnt + 16'd1});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},       64'(WRITE_ENABLE), 64'd0);
    check({tag, "_load_run"}, 64'(LOAD_RUN),     64'd0);
    check({tag, "_running"},  64'(RUNNING),      64'd0);
    check({tag, "_gen_count"}, 64'(GEN_COUNT),   64'd0);
    check({tag, "_gen_done"}, 64'(GEN_DONE),     64'd0);
    check({tag, "_state"},    64'(DBG_STATE),    64'(IDLE));
  endtask

  task automatic do_load();
    tick();
    LOAD_REQ = 1'b1;
    expect_write(cyc + 1, 1'b0, exp_cnt);
    exp_cnt = '0;
    tick();
    LOAD_REQ = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_step();
    tick();
    STEP = 1'b1;
    expect_write(cyc + 1, 1'b1, exp_cnt);
    exp_cnt = exp_cnt + 16'd1;
    tick();
    STEP = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (WRITE_ENABLE) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: actual cyc=%0d lr=%0b cnt=%0d required none", cyc, LOAD_RUN, GEN_COUNT);
        end else begin
          logic [WW-1:0] e;
          e = exp_q.pop_front();
          if ({32'(cyc), LOAD_RUN, GEN_COUNT} !== e) begin
            n_err++;
            $display("FAIL write: actual cyc=%0d lr=%0b cnt=%0d required cyc=%0d lr=%0b cnt=%0d",
                     cyc, LOAD_RUN, GEN_COUNT, e[WW-1 -: 32], e[GW], e[GW-1:0]);
          end
        end
      end
      if (GEN_DONE) begin
        n_cmp++;
        if (done_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_gen_done: actual cyc=%0d cnt=%0d required none", cyc, GEN_COUNT);
        end else begin
          logic [DW-1:0] d;
          d = done_q.pop_front();
          if ({32'(cyc), GEN_COUNT} !== d) begin
            n_err++;
            $display("FAIL gen_done: actual cyc=%0d cnt=%0d required cyc=%0d cnt=%0d",
                     cyc, GEN_COUNT, d[DW-1 -: 32], d[GW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int c;
    repeat (3) tick();
    check_reset_outputs("reset_hold");
    RESET_N = 1'b1;
    tick();
    check_reset_outputs("after_reset");

    // Pattern load: one write with LOAD_RUN=0, count cleared, no GEN_DONE.
    do_load();
    check("load_count", 64'(GEN_COUNT), 64'd0);

    // Three single steps.
    do_step();
    do_step();
    do_step();
    check("step_count", 64'(GEN_COUNT), 64'd3);

    // Free-run PERIOD=3: writes 5 cycles apart, STOP in WAIT ends without a write.
    PERIOD = 16'd3;
    GEN_LIMIT = 16'd0;
    tick();
    START = 1'b1;
    c = cyc;
    for (int n = 0; n < 5; n++) expect_write(c + 5 + 5 * n, 1'b1, exp_cnt + 16'(n));
    exp_cnt = exp_cnt + 16'd5;
    tick();
    START = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      check("run_running", 64'(RUNNING), 64'd1);
      tick();
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check("stop_wait_running", 64'(RUNNING), 64'd0);
    check("stop_wait_state", 64'(DBG_STATE), 64'(IDLE));
    check("run_count", 64'(GEN_COUNT), 64'd8);

    // PERIOD=0 with GEN_LIMIT=4 from count 0: alternate-cycle writes, auto-stop.
    do_load();
    PERIOD = 16'd0;
    GEN_LIMIT = 16'd4;
    tick();
    START = 1'b1;
    c = cyc;
    for (int n = 0; n < 4; n++) expect_write(c + 2 + 2 * n, 1'b1, 16'(n));
    exp_cnt = 16'd4;
    tick();
    START = 1'b0;
    repeat (9) tick();
    check("limit_count", 64'(GEN_COUNT), 64'd4);
    check("limit_running", 64'(RUNNING), 64'd0);
    check("limit_state", 64'(DBG_STATE), 64'(IDLE));
    GEN_LIMIT = 16'd0;

    // STOP in the same cycle the interval reaches zero: no write.
    PERIOD = 16'd2;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (2) tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check("stop_zero_state", 64'(DBG_STATE), 64'(IDLE));
    check("stop_zero_count", 64'(GEN_COUNT), 64'd4);

    // STOP during RUN_UPD: that write completes, then IDLE.
    tick();
    START = 1'b1;
    c = cyc;
    expect_write(c + 4, 1'b1, exp_cnt);
    exp_cnt = exp_cnt + 16'd1;
    tick();
    START = 1'b0;
    repeat (3) tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    check("stop_upd_state", 64'(DBG_STATE), 64'(IDLE));
    check("stop_upd_count", 64'(GEN_COUNT), 64'd5);

    // START and STOP together in IDLE: one WAIT cycle, then IDLE.
    PERIOD = 16'd4;
    tick();
    START = 1'b1;
    STOP = 1'b1;
    tick();
    check("start_stop_wait", 64'(DBG_STATE), 64'(WAIT));
    check("start_stop_running", 64'(RUNNING), 64'd1);
    tick();
    START = 1'b0;
    STOP = 1'b0;
    check("start_stop_idle", 64'(DBG_STATE), 64'(IDLE));

    // Asynchronous reset in the middle of WAIT.
    PERIOD = 16'd5;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    check("pre_rst_wait", 64'(DBG_STATE), 64'(WAIT));
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    exp_cnt = '0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();

    // Asynchronous reset in the middle of RUN_UPD.
    do_step();
    PERIOD = 16'd1;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (2) tick();
    check("pre_rst_upd_we", 64'(WRITE_ENABLE), 64'd1);
    check("pre_rst_upd_count", 64'(GEN_COUNT), 64'd1);
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("rst_upd");
    exp_cnt = '0;
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (5) tick();

    // Every expected write and GEN_DONE pulse must have been seen.
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("dones_left", 64'(done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/generation_controller.md
# generation_controller

Sequencer for the grid memory of the Conway engine. Drives the memory's `WRITE_ENABLE` and `LOAD_RUN` controls so the memory can:
- load an initial pattern,
- advance one generation on request (single step), or
- free-run generations at a programmable interval.

It also counts generations, signals completion of each write, and optionally halts at a generation limit. It sits between the user/host control inputs and the memory; the next-state grid logic stays combinational and is not owned here.

## Interface
- `PERIOD_WIDTH`, default 16: width of the inter-generation interval setting.
- `GEN_WIDTH`, default 16: width of the generation counter and limit.
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `LOAD_REQ` input 1: request a write of the initial pattern (level, sampled each cycle).
- `START` input 1: begin free-running generations.
- `STOP` input 1: halt free-running.
- `STEP` input 1: perform exactly one generation update.
- `PERIOD` input `PERIOD_WIDTH`: idle cycles between free-run updates; sampled on each entry to WAIT.
- `GEN_LIMIT` input `GEN_WIDTH`: auto-stop when `GEN_COUNT` reaches this value; 0 disables the limit.
- `WRITE_ENABLE` output 1: memory write strobe.
- `LOAD_RUN` output 1: memory source select, where 0 = initial pattern and 1 = grid logic.
- `RUNNING` output 1: high in WAIT, and in UPDATE entered from WAIT.
- `GEN_COUNT` output `GEN_WIDTH`: generations written since the last load.
- `GEN_DONE` output 1: one-cycle pulse in the cycle after any grid-logic write.

## Operation
- States (shared enum): IDLE, LOAD, STEP_UPD, WAIT, RUN_UPD.
- Outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- IDLE
  - `WRITE_ENABLE`=0 and `LOAD_RUN`=0.
  - Input priority: `LOAD_REQ` > `STEP` > `START`.
  - `LOAD_REQ` → LOAD; `STEP` → STEP_UPD; `START` → WAIT, loading the interval counter with `PERIOD`.
- LOAD
  - Lasts 1 cycle with `WRITE_ENABLE`=1 and `LOAD_RUN`=0.
  - `GEN_COUNT` is cleared to 0 at the end of the cycle.
  - Next state is always IDLE.
- STEP_UPD
  - Lasts 1 cycle with `WRITE_ENABLE`=1 and `LOAD_RUN`=1.
  - `GEN_COUNT` increments.
  - Next state is always IDLE.
- WAIT
  - `WRITE_ENABLE`=0 and `LOAD_RUN`=1.
  - `STOP` → IDLE, with highest priority.
  - Counter == 0 → RUN_UPD; otherwise the counter decrements.
  - `LOAD_REQ`, `START` and `STEP` are ignored.
- RUN_UPD
  - Lasts 1 cycle with `WRITE_ENABLE`=1 and `LOAD_RUN`=1.
  - `GEN_COUNT` increments.
  - If `STOP` is high, or `GEN_LIMIT`≠0 and the incremented count equals `GEN_LIMIT` → IDLE.
  - Otherwise → WAIT, with the counter reloaded from `PERIOD`.
  - The write in progress always completes; `STOP` never aborts RUN_UPD.
- `GEN_COUNT` wraps from 2^`GEN_WIDTH`−1 to 0, and there is no flag on wrap.
- `GEN_LIMIT` is checked only in RUN_UPD. STEP_UPD may pass the limit without effect.
- If `GEN_LIMIT` ≤ current `GEN_COUNT` at `START`, free-running continues until the count wraps back to the limit.

## Timing
- Reset values: state IDLE, `WRITE_ENABLE`=0, `LOAD_RUN`=0, `RUNNING`=0, `GEN_COUNT`=0, `GEN_DONE`=0, interval counter 0.
- Reset is asynchronous; `WRITE_ENABLE` drops immediately, including mid-write. Memory contents are then undefined for that write.
- Request at edge k, sampled in IDLE → `WRITE_ENABLE` high during cycle k+1.
- `GEN_DONE` is high during cycle k+2 for STEP; it is never asserted for LOAD.
- Free-run: WAIT lasts `PERIOD`+1 cycles, so the update period is `PERIOD`+2 cycles.
  - `PERIOD`=0 gives a write every 2nd cycle.
- `STOP` asserted in the same cycle as WAIT's counter reaching 0 → IDLE, with no write.
- `START` and `STOP` both high in IDLE → enter WAIT, then exit to IDLE on the next cycle.

## Structure
- Package `generation_controller_pkg` holds the state enum `gen_state_t` and the reset values.
- Sub-module `interval_timer` (parameterised by `PERIOD_WIDTH`):
  - inputs `LOAD` and `LOAD_VALUE`, output `ZERO`;
  - down-counts while not zero; uses the same `CLK`/`RESET_N`.
- Top level = FSM + generation counter + `GEN_DONE` register.

## Test plan
- Reset, then hold `LOAD_REQ`=1 for 1 cycle → exactly 1 cycle with `WRITE_ENABLE`=1, `LOAD_RUN`=0; `GEN_COUNT`=0; `GEN_DONE` stays 0.
- `STEP` pulse 3 times, with IDLE gaps between → 3 single-cycle writes with `LOAD_RUN`=1; `GEN_COUNT`=3; 3 `GEN_DONE` pulses, each 1 cycle after its write.
- `PERIOD`=3, `START` pulse, run 30 cycles → writes exactly 5 cycles apart; `RUNNING`=1 throughout; `GEN_COUNT` increments per write.
- `PERIOD`=0, `GEN_LIMIT`=4, `START` from count 0 → writes on alternating cycles; the FSM returns to IDLE after the 4th write; `GEN_COUNT`=4; `RUNNING`=0.
- `STOP` during WAIT → no further write; `STOP` asserted during RUN_UPD → that write completes, then IDLE.
- Assert `RESET_N`=0 mid-WAIT and mid-RUN_UPD → all outputs at reset values immediately; `GEN_COUNT`=0.
